clk_switch_ctrl: RTL and testbench

- clk_A-domain controller that owns the `sel` input of the glitch-free clk_A/clk_B switch that sits directly downstream.
- Accepts valid/ready switch requests and confirms clk_B is toggling before ever selecting it.
- Holds off completion until the switch's internal sync chains have settled, then reports done or err.
- Prevents selecting a dead clk_B, which would leave clk_out stuck low.

---
 rtl/clk_switch_pkg.sv | 23 ++
 rtl/clk_activity_det.sv | 53 +++++
 rtl/clk_switch_ctrl.sv | 129 ++++++++++++
 tb/tb_clk_switch_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_switch_pkg.sv
// Shared types and defaults for the clk_A/clk_B switch controller.
// The sel encodings match the downstream glitch-free switch.
package clk_switch_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StChkB   = 2'd1,
        StSettle = 2'd2
    } state_e;

    localparam int unsigned CHK_WIN_DEF    = 32;
    localparam int unsigned MIN_EDGES_DEF  = 4;
    localparam int unsigned SETTLE_CYC_DEF = 8;

    localparam logic SEL_CLK_A = 1'b0;
    localparam logic SEL_CLK_B = 1'b1;

    // One spare bit so a counter can hold its terminal value without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/clk_activity_det.sv
// Detects activity on an asynchronous divided clock: 2-flop synchronizer, an
// edge-detect flop and a saturating edge counter.
module clk_activity_det
    import clk_switch_pkg::*;
#(
    parameter int unsigned MIN_EDGES = MIN_EDGES_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clr_i,
    input  logic async_i,
    output logic edge_o,
    output logic alive_o,
    output logic near_o
);

    localparam int unsigned CntW = cnt_width(MIN_EDGES);
    localparam logic [CntW-1:0] CntMax  = CntW'(MIN_EDGES);
    localparam logic [CntW-1:0] CntNear = CntW'(MIN_EDGES - 1);

    logic            s1_q, s2_q, s3_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            s3_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= async_i;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            cnt_q <= cnt_d;
        end
    end

    assign edge_o = s2_q ^ s3_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (edge_o && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign alive_o = (cnt_q == CntMax);
    // One more edge completes the count; lets the FSM act in the same cycle.
    assign near_o  = (cnt_q == CntNear);

endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_A-domain owner of the clock switch's sel input: verifies clk_B is toggling
// before selecting it, then waits for the switch's sync chains before reporting.
module clk_switch_ctrl
    import clk_switch_pkg::*;
#(
    parameter int unsigned CHK_WIN    = CHK_WIN_DEF,
    parameter int unsigned MIN_EDGES  = MIN_EDGES_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic clk_A,
    input  logic rstn_A,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic clk_b_div,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err
);

    localparam int unsigned WinW = cnt_width(CHK_WIN);
    localparam int unsigned SetW = cnt_width(SETTLE_CYC);
    localparam logic [WinW-1:0] WinLast = WinW'(CHK_WIN - 1);
    localparam logic [SetW-1:0] SetLast = SetW'(SETTLE_CYC - 1);

    state_e          state_q, state_d;
    logic            sel_q, sel_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [WinW-1:0] win_q, win_d;
    logic [SetW-1:0] set_q, set_d;

    logic det_clr, b_edge, b_alive, b_near, b_ok;

    // Edge counting only runs while checking; everywhere else it is held cleared.
    assign det_clr = (state_q != StChkB);

    clk_activity_det #(
        .MIN_EDGES(MIN_EDGES)
    ) u_act_det (
        .clk_i   (clk_A),
        .rstn_i  (rstn_A),
        .clr_i   (det_clr),
        .async_i (clk_b_div),
        .edge_o  (b_edge),
        .alive_o (b_alive),
        .near_o  (b_near)
    );

    assign b_ok = b_alive || (b_near && b_edge);

    always_ff @(posedge clk_A or negedge rstn_A) begin
        if (!rstn_A) begin
            state_q <= StIdle;
            sel_q   <= SEL_CLK_A;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            win_q   <= '0;
            set_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            err_q   <= err_d;
            win_q   <= win_d;
            set_q   <= set_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        win_d   = win_q;
        set_d   = set_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else if (req_sel == SEL_CLK_B) begin
                        win_d   = '0;
                        state_d = StChkB;
                    end else begin
                        // clk_A is always running, so falling back needs no check.
                        sel_d   = SEL_CLK_A;
                        set_d   = '0;
                        state_d = StSettle;
                    end
                end
            end
            StChkB: begin
                win_d = win_q + 1'b1;
                if (b_ok) begin
                    sel_d   = SEL_CLK_B;
                    set_d   = '0;
                    state_d = StSettle;
                end else if (win_q == WinLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end
            end
            StSettle: begin
                set_d = set_q + 1'b1;
                if (set_q == SetLast) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sel       = sel_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = (state_q != StIdle);
    assign req_ready = (state_q == StIdle);

    done_err_excl_a: assert property (@(posedge clk_A) disable iff (!rstn_A)
        !(done_q && err_q));

    // sel may only move on the edge that enters SETTLE.
    sel_move_a: assert property (@(posedge clk_A) disable iff (!rstn_A)
        (sel_q != $past(sel_q)) |-> (state_q == StSettle));

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Self-checking bench for clk_switch_ctrl: randomized clk_b_div activity checked
// against a cycle-trace model derived from the controller's timing rules.
module tb_clk_switch_ctrl;

    localparam int CHK_WIN    = 32;
    localparam int MIN_EDGES  = 4;
    localparam int SETTLE_CYC = 8;
    localparam int NOBS       = 64;

    logic clk_A     = 1'b0;
    logic rstn_A    = 1'b1;
    logic req_valid = 1'b0;
    logic req_sel   = 1'b0;
    logic clk_b_div = 1'b0;
    logic req_ready, sel, busy, done, err;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // hist[n] = clk_b_div as sampled by the DUT at posedge number n.
    bit hist [0:16383];

    logic [NOBS-1:0] obs_sel, obs_done, obs_err, obs_busy, obs_ready;

    int gen_mode = 0;
    int gen_lo   = 3;
    int gen_hi   = 3;

    clk_switch_ctrl #(
        .CHK_WIN    (CHK_WIN),
        .MIN_EDGES  (MIN_EDGES),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk_A     (clk_A),
        .rstn_A    (rstn_A),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .clk_b_div (clk_b_div),
        .sel       (sel),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk_A = ~clk_A;

    always @(posedge clk_A) begin
        cyc              <= cyc + 1;
        hist[cyc + 1]    <= clk_b_div;
    end

    // clk_b_div source: mode 0 holds it low, mode 1 toggles every gen_lo..gen_hi cycles.
    initial begin
        int cd;
        cd = 1;
        forever begin
            @(negedge clk_A);
            if (gen_mode == 0) begin
                clk_b_div = 1'b0;
            end else if (cd <= 1) begin
                clk_b_div = ~clk_b_div;
                cd = $urandom_range(gen_hi, gen_lo);
            end else begin
                cd = cd - 1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // A toggle sampled at edge k is seen by the checker two edges later; counting
    // starts with the cycle after acceptance (edge t) and the window is CHK_WIN
    // cycles. Returns the trace index at which sel should first read 1, or -1.
    function automatic int model_hit(input int t);
        int c;
        c = 0;
        for (int n = t; n <= t + CHK_WIN - 1; n++) begin
            if (hist[n-1] != hist[n-2]) c++;
            if (c >= MIN_EDGES) return n + 1 - t;
        end
        return -1;
    endfunction

    // Present one request; trace index k holds outputs after edge t+k.
    task automatic issue(input logic tsel, output int t);
        @(negedge clk_A);
        req_valid = 1'b1;
        req_sel   = tsel;
        t         = cyc + 1;
        for (int k = 0; k < NOBS; k++) begin
            @(negedge clk_A);
            if (k == 0) begin
                req_valid = 1'b0;
                req_sel   = 1'($urandom_range(1, 0));
            end
            obs_sel[k]   = sel;
            obs_done[k]  = done;
            obs_err[k]   = err;
            obs_busy[k]  = busy;
            obs_ready[k] = req_ready;
        end
    endtask

    task automatic test_reset();
        gen_lo   = 1;
        gen_hi   = 2;
        gen_mode = 1;
        rstn_A   = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_A);
            req_valid = 1'($urandom_range(1, 0));
            req_sel   = 1'($urandom_range(1, 0));
            n_run++;
            if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
                n_fail++;
                $display("FAIL reset_hold: {sel,ready,busy,done,err}=%b required 01000",
                         {sel, req_ready, busy, done, err});
            end
        end
        @(negedge clk_A);
        req_valid = 1'b0;
        rstn_A    = 1'b1;
        repeat (3) begin
            @(negedge clk_A);
            n_run++;
            if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
                n_fail++;
                $display("FAIL reset_release: {sel,ready,busy,done,err}=%b required 01000",
                         {sel, req_ready, busy, done, err});
            end
        end
        gen_mode = 0;
    endtask

    task automatic test_same_target(input logic cur);
        int t;
        logic [NOBS-1:0] e_sel, e_done;
        issue(cur, t);
        e_sel   = cur ? '1 : '0;
        e_done  = '0;
        e_done[0] = 1'b1;
        n_run++;
        if (obs_sel !== e_sel) begin
            n_fail++;
            $display("FAIL same_sel: got %h required %h", obs_sel, e_sel);
        end
        n_run++;
        if (obs_done !== e_done) begin
            n_fail++;
            $display("FAIL same_done: got %h required %h", obs_done, e_done);
        end
        n_run++;
        if ((obs_busy | obs_err) !== '0) begin
            n_fail++;
            $display("FAIL same_busy_err: busy %h err %h required 0", obs_busy, obs_err);
        end
    endtask

    task automatic test_to_a(input string name);
        int t;
        logic [NOBS-1:0] e_done, e_busy;
        issue(1'b0, t);
        e_done = '0;
        e_done[SETTLE_CYC] = 1'b1;
        e_busy = '0;
        for (int k = 0; k < SETTLE_CYC; k++) e_busy[k] = 1'b1;
        n_run++;
        if (obs_sel !== '0) begin
            n_fail++;
            $display("FAIL %s_sel: got %h required 0", name, obs_sel);
        end
        n_run++;
        if (obs_done !== e_done) begin
            n_fail++;
            $display("FAIL %s_done: got %h required %h", name, obs_done, e_done);
        end
        n_run++;
        if (obs_busy !== e_busy || obs_ready !== ~e_busy) begin
            n_fail++;
            $display("FAIL %s_busy: busy %h ready %h required busy %h", name, obs_busy,
                     obs_ready, e_busy);
        end
        n_run++;
        if (obs_err !== '0) begin
            n_fail++;
            $display("FAIL %s_err: got %h required 0", name, obs_err);
        end
    endtask

    task automatic test_to_b(input string name, input int lo, input int hi, input bit dead,
                             output int h);
        int t;
        logic [NOBS-1:0] e_sel, e_done, e_err, e_busy;
        if (dead) begin
            gen_mode = 0;
            repeat (4) @(negedge clk_A);
        end else begin
            gen_lo   = lo;
            gen_hi   = hi;
            gen_mode = 1;
        end
        issue(1'b1, t);
        h      = model_hit(t);
        e_sel  = '0;
        e_done = '0;
        e_err  = '0;
        e_busy = '0;
        if (h >= 0) begin
            for (int k = h; k < NOBS; k++) e_sel[k] = 1'b1;
            e_done[h + SETTLE_CYC] = 1'b1;
            for (int k = 0; k < h + SETTLE_CYC; k++) e_busy[k] = 1'b1;
        end else begin
            e_err[CHK_WIN] = 1'b1;
            for (int k = 0; k < CHK_WIN; k++) e_busy[k] = 1'b1;
        end
        n_run++;
        if (obs_sel !== e_sel) begin
            n_fail++;
            $display("FAIL %s_sel: got %h required %h", name, obs_sel, e_sel);
        end
        n_run++;
        if (obs_done !== e_done) begin
            n_fail++;
            $display("FAIL %s_done: got %h required %h", name, obs_done, e_done);
        end
        n_run++;
        if (obs_err !== e_err) begin
            n_fail++;
            $display("FAIL %s_err: got %h required %h", name, obs_err, e_err);
        end
        n_run++;
        if (obs_busy !== e_busy || obs_ready !== ~e_busy) begin
            n_fail++;
            $display("FAIL %s_busy: busy %h ready %h required busy %h", name, obs_busy,
                     obs_ready, e_busy);
        end
    endtask

    task automatic wait_sel_high(input string name);
        int w;
        w = 0;
        while (sel !== 1'b1 && w < 40) begin
            @(negedge clk_A);
            w++;
        end
        n_run++;
        if (sel !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_reach_b: sel=%b required 1 within 40 cycles", name, sel);
        end
    endtask

    // A to-A request held through SETTLE must be taken only once req_ready is back.
    task automatic test_settle_hold();
        int d, z, e;
        d = -1;
        z = -1;
        e = -1;
        gen_lo   = 3;
        gen_hi   = 3;
        gen_mode = 1;
        @(negedge clk_A);
        req_valid = 1'b1;
        req_sel   = 1'b1;
        @(negedge clk_A);
        req_valid = 1'b0;
        wait_sel_high("hold");
        repeat (2) @(negedge clk_A);
        req_valid = 1'b1;
        req_sel   = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk_A);
            if (d < 0 && done === 1'b1) d = k;
            else if (z >= 0 && e < 0 && done === 1'b1) e = k;
            if (z < 0 && sel === 1'b0) begin
                z = k;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_run++;
        if (d < 0 || z != d + 1) begin
            n_fail++;
            $display("FAIL hold_accept: sel fell at %0d, done at %0d; required fall = done+1",
                     z, d);
        end
        n_run++;
        if (z < 0 || e != z + SETTLE_CYC) begin
            n_fail++;
            $display("FAIL hold_a_done: done at %0d required %0d", e, z + SETTLE_CYC);
        end
    endtask

    task automatic check_quiet(input string name, input int ncyc);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk_A);
            if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || sel !== 1'b0) bad = 1'b1;
        end
        n_run++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_quiet: done/err/busy/sel activity after reset, required none",
                     name);
        end
    endtask

    task automatic async_reset(input string name, input logic [1:0] pre);
        n_run++;
        if ({busy, sel} !== pre) begin
            n_fail++;
            $display("FAIL %s_pre: {busy,sel}=%b required %b", name, {busy, sel}, pre);
        end
        #2 rstn_A = 1'b0;
        #1;
        n_run++;
        if ({sel, req_ready, busy, done, err} !== 5'b01000) begin
            n_fail++;
            $display("FAIL %s_async: {sel,ready,busy,done,err}=%b required 01000", name,
                     {sel, req_ready, busy, done, err});
        end
        repeat (2) @(negedge clk_A);
        rstn_A = 1'b1;
    endtask

    task automatic test_reset_mid_chk();
        int h;
        gen_lo   = 3;
        gen_hi   = 3;
        gen_mode = 1;
        @(negedge clk_A);
        req_valid = 1'b1;
        req_sel   = 1'b1;
        @(negedge clk_A);
        req_valid = 1'b0;
        repeat (4) @(negedge clk_A);
        async_reset("rst_chk", 2'b10);
        check_quiet("rst_chk", 40);
        test_to_b("rst_chk_next", 3, 3, 1'b0, h);
        if (h >= 0) test_to_a("rst_chk_back");
    endtask

    task automatic test_reset_mid_settle();
        int h;
        gen_lo   = 2;
        gen_hi   = 4;
        gen_mode = 1;
        @(negedge clk_A);
        req_valid = 1'b1;
        req_sel   = 1'b1;
        @(negedge clk_A);
        req_valid = 1'b0;
        wait_sel_high("rst_set");
        repeat (3) @(negedge clk_A);
        async_reset("rst_set", 2'b11);
        check_quiet("rst_set", 20);
        test_to_b("rst_set_next", 2, 4, 1'b0, h);
        if (h >= 0) test_to_a("rst_set_back");
    endtask

    initial begin
        int h, lo;
        test_reset();
        test_same_target(1'b0);
        test_to_b("b_per3", 3, 3, 1'b0, h);
        if (h >= 0) begin
            test_same_target(1'b1);
            test_to_a("a_from_b");
        end
        test_to_b("b_dead", 0, 0, 1'b1, h);
        test_settle_hold();
        for (int i = 0; i < 10; i++) begin
            lo = $urandom_range(4, 1);
            test_to_b("b_rand", lo, lo + $urandom_range(8, 0), 1'b0, h);
            if (h >= 0) test_to_a("a_rand");
        end
        test_reset_mid_chk();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
